// File: rtl/ama_riscv_wb_arbiter.sv
// ama_riscv_wb_arbiter: merges pipeline and long-latency writebacks onto one RF port with a pending-write scoreboard
module ama_riscv_wb_arbiter #(
   parameter int XLEN          = 32,
   parameter int LL_FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            p_we_rd,
   input  logic            p_we_rdp,
   input  logic [4:0]      p_addr,
   input  logic [XLEN-1:0] p_data,
   input  logic [XLEN-1:0] p_data_p,
   input  logic            ll_valid,
   output logic            ll_ready,
   input  logic            ll_rdp,
   input  logic [4:0]      ll_addr,
   input  logic [XLEN-1:0] ll_data,
   input  logic [XLEN-1:0] ll_data_p,
   input  logic            iss_valid,
   input  logic            iss_rdp,
   input  logic [4:0]      iss_addr,
   output logic            iss_ready,
   input  logic [4:0]      chk_addr_a,
   input  logic [4:0]      chk_addr_b,
   input  logic [4:0]      chk_addr_c,
   output logic            chk_busy_a,
   output logic            chk_busy_b,
   output logic            chk_busy_c,
   output logic            stall_req,
   output logic            rf_we_rd,
   output logic            rf_we_rdp,
   output logic [4:0]      rf_addr_d,
   output logic [XLEN-1:0] rf_data_d,
   output logic [XLEN-1:0] rf_data_dp
);
   localparam int AW = $clog2(LL_FIFO_DEPTH);
   localparam int CW = $clog2(LL_FIFO_DEPTH + 1);

   logic [CW-1:0]   cnt;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            f_rdp  [LL_FIFO_DEPTH];
   logic [4:0]      f_addr [LL_FIFO_DEPTH];
   logic [XLEN-1:0] f_data [LL_FIFO_DEPTH];
   logic [XLEN-1:0] f_data_p [LL_FIFO_DEPTH];
   logic [31:0]     pend, pend_n;
   logic            ll_src_q;
   logic            full, empty, ll_fire, sel_p, sel_f, sel_b, push, pop, src_v;
   logic            src_rdp;
   logic [4:0]      src_addr, iss_addr_p, rf_addr_p;
   logic [XLEN-1:0] src_data, src_data_p;

   assign full       = cnt == CW'(LL_FIFO_DEPTH);
   assign empty      = cnt == '0;
   assign ll_ready   = !rst && !full;
   assign ll_fire    = ll_valid && ll_ready;
   assign sel_p      = p_we_rd;
   assign sel_f      = !p_we_rd && !empty;
   assign sel_b      = !p_we_rd && empty && ll_fire;
   assign push       = ll_fire && !sel_b;
   assign pop        = sel_f;
   assign src_v      = sel_p || sel_f || sel_b;
   assign src_rdp    = sel_p ? p_we_rdp : sel_f ? f_rdp[rd_ptr] : ll_rdp;
   assign src_addr   = sel_p ? p_addr : sel_f ? f_addr[rd_ptr] : ll_addr;
   assign src_data   = sel_p ? p_data : sel_f ? f_data[rd_ptr] : ll_data;
   assign src_data_p = sel_p ? p_data_p : sel_f ? f_data_p[rd_ptr] : ll_data_p;
   assign stall_req  = full || (cnt == CW'(LL_FIFO_DEPTH - 1) && ll_valid && p_we_rd);
   assign iss_addr_p = iss_addr + 5'd1;
   assign rf_addr_p  = rf_addr_d + 5'd1;
   assign iss_ready  = !(pend[iss_addr] || (iss_rdp && pend[iss_addr_p]));
   assign chk_busy_a = pend[chk_addr_a];
   assign chk_busy_b = pend[chk_addr_b];
   assign chk_busy_c = pend[chk_addr_c];

   // Next scoreboard: clear the LL destination now visible in the RF, then apply new issue (set wins); x0 never pending
   always_comb begin
      pend_n = pend;
      if (rf_we_rd && ll_src_q) pend_n = pend_n & ~((32'd1 << rf_addr_d) | (rf_we_rdp ? 32'd1 << rf_addr_p : 32'd0));
      if (iss_valid && iss_ready && iss_addr != 5'd0) pend_n = pend_n | (32'd1 << iss_addr) | (iss_rdp ? 32'd1 << iss_addr_p : 32'd0);
      pend_n = pend_n & ~32'd1;
   end

   // Control state: FIFO occupancy, pointers, scoreboard and registered RF write port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pend       <= '0;
         ll_src_q   <= 1'b0;
         rf_we_rd   <= 1'b0;
         rf_we_rdp  <= 1'b0;
         rf_addr_d  <= '0;
         rf_data_d  <= '0;
         rf_data_dp <= '0;
      end else begin
         cnt       <= cnt + CW'(push) - CW'(pop);
         wr_ptr    <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr    <= pop ? rd_ptr + AW'(1) : rd_ptr;
         pend      <= pend_n;
         ll_src_q  <= src_v && !sel_p;
         rf_we_rd  <= src_v;
         rf_we_rdp <= src_v && src_rdp && src_addr != 5'd0 && src_addr != 5'd31;
         if (src_v) begin
            rf_addr_d  <= src_addr;
            rf_data_d  <= src_data;
            rf_data_dp <= src_data_p;
         end
      end
   end

   // Buffered long-latency results; contents need no reset since occupancy gates their use
   always_ff @(posedge clk) begin
      if (push) begin
         f_rdp[wr_ptr]    <= ll_rdp;
         f_addr[wr_ptr]   <= ll_addr;
         f_data[wr_ptr]   <= ll_data;
         f_data_p[wr_ptr] <= ll_data_p;
      end
   end

`ifndef SYNTHESIS
   // Illegal traffic: pair on x31, or the pipeline overwriting a register still owed by the long-latency unit
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(src_v && src_rdp && src_addr == 5'd31)) else $fatal(1, "paired write with rd=x31");
         assert (!(p_we_rd && pend[p_addr])) else $fatal(1, "pipeline write to pending register");
      end
   end
`endif
endmodule

// File: doc/ama_riscv_wb_arbiter.md
Name: ama_riscv_wb_arbiter

Overview:
Writer side of the register-file write port. Merges in-order pipeline writeback with out-of-order results from the long-latency unit (mul/div/load-miss) onto the single rd/rdp write port. Keeps a pending-write scoreboard so decode can stall on RAW/WAW hazards against in-flight long-latency destinations. Sits between the writeback stage, the long-latency unit and the register file.

Parameters:
XLEN, 32, architectural data width
LL_FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
p_we_rd  in  1  pipeline writes rd
p_we_rdp  in  1  pipeline also writes rdp = rd+1 (valid only with p_we_rd)
p_addr  in  5  pipeline rd
p_data  in  XLEN  pipeline rd data
p_data_p  in  XLEN  pipeline rdp data
ll_valid  in  1  long-latency result valid
ll_ready  out  1  buffer can accept
ll_rdp  in  1  result is paired
ll_addr  in  5  result rd
ll_data  in  XLEN  rd data
ll_data_p  in  XLEN  rdp data
iss_valid  in  1  long-latency op issued this cycle
iss_rdp  in  1  issued op writes a pair
iss_addr  in  5  issued op rd
iss_ready  out  1  no WAW conflict, issue allowed
chk_addr_a/b/c  in  5 each  decode source operands
chk_busy_a/b/c  out  1 each  operand pending
stall_req  out  1  buffer full, pipeline must bubble writeback
rf_we_rd  out  1  RF write enable rd
rf_we_rdp  out  1  RF write enable rdp
rf_addr_d  out  5  RF rd
rf_data_d  out  XLEN  RF rd data
rf_data_dp  out  XLEN  RF rdp data

Behaviour:
- Reset: all rf_* outputs 0, FIFO empty, scoreboard clear, stall_req 0; ll_ready 0 while rst high, 1 from first cycle after deassertion. Reset mid-operation discards buffered results and pending bits; no RF write issued.
- Output stage registered; every accepted write appears on rf_* exactly 1 cycle after its source selection; one write per cycle.
- Selection each cycle, priority order: (1) pipeline if p_we_rd; (2) FIFO head if non-empty; (3) ll input bypass if FIFO empty and ll_valid. No source: rf_we_rd=rf_we_rdp=0, addr/data hold.
- ll handshake: transfer when ll_valid && ll_ready; ll_ready = !full. Accepted result not bypassed enters FIFO (FIFO pushes and pops in the same cycle allowed, including when full: pop frees slot, ll_ready stays combinationally !full at cycle start).
- stall_req = FIFO full || (FIFO count == LL_FIFO_DEPTH-1 && ll_valid && p_we_rd).
- Paired write: rf_we_rdp = source rdp flag. rdp with rd=x31 illegal: rdp enable dropped, sim-only fatal assertion. Write to x0 passes through with rf_we_rd as given (RF ignores it); rdp of x0 dropped (rf_we_rdp=0).
- Scoreboard: 31 bits (x1..x31). iss_valid && iss_ready sets bit iss_addr, plus iss_addr+1 if iss_rdp; iss_addr=x0 sets nothing.
- iss_ready = 0 if target bit (or pair bit) already set; combinational.
- Bit clear on the clock edge ending a cycle in which rf_we_rd is high for an LL-sourced write (and rdp bit if rf_we_rdp): busy drops in the cycle the data becomes readable in RF. Same-cycle set and clear of the same bit: set wins.
- chk_busy_x = pending bit of chk_addr_x; x0 always 0. Combinational, no internal forwarding.
- Sim-only assertion: pipeline write to a pending register is fatal.

Test Plan:
- Reset then idle: rst pulse -> all rf_* 0, ll_ready 0 during rst then 1, chk_busy_* 0 for all addresses.
- Pipeline-only: p_we_rd=1, p_addr=5, p_data=0xDEADBEEF at cycle t -> rf_we_rd=1, rf_addr_d=5, rf_data_d=0xDEADBEEF at t+1, rf_we_rdp=0.
- Bypass pair: issue x10 rdp, later ll_valid addr=10 rdp data 0x11/0x22 with pipeline idle -> next cycle rf_we_rd=rf_we_rdp=1, data_d=0x11, data_dp=0x22; chk_busy for x10,x11 is 1 until that cycle, 0 after.
- Collision and buffering: ll result x7 arrives while pipeline writes x3 for 3 cycles -> x3 writes first, x7 buffered, x7 written cycle after pipeline idle; 3rd ll result with depth 2 full -> ll_ready=0, stall_req=1.
- WAW block: x12 pending, iss_addr=12 -> iss_ready=0; iss_addr=11 iss_rdp=1 -> iss_ready=0; iss_addr=13 -> iss_ready=1.
- Reset mid-operation: two buffered results and 3 pending bits, assert rst -> no rf_we_rd after reset, all chk_busy 0, FIFO empty (ll_ready=1).
